dram_port_arbiter: RTL and testbench

- Shares the single-port DataRAM between two requesters: port 0 is the CPU load/store path, port 1 is a host loader/debug port that preloads or inspects data memory.
- Each cycle it grants at most one access, drives the DataRAM command and returns registered read data to the winner.
- A bounded-streak fairness rule prevents starvation.
- The CPU uses Stall0 to freeze its PC while its access waits.

---
 rtl/dram_port_arbiter_pkg.sv | 12 +
 rtl/arb_streak_ctr.sv | 64 ++++++
 rtl/dram_port_arbiter.sv | 104 ++++++++++
 tb/tb_dram_port_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// Shared constants for the DataRAM port arbiter: port indices and default widths.
package dram_port_arbiter_pkg;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam int unsigned DEF_ADDR_W     = 5;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_MAX_STREAK = 4;
    localparam int unsigned STREAK_W       = 4;

endpackage

// File: rtl/arb_streak_ctr.sv
// Two-way arbiter with bounded-streak fairness: the owner keeps winning contested
// cycles until it has been granted MAX_STREAK times in a row.
module arb_streak_ctr
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_STREAK);

    logic                r_owner;
    logic [STREAK_W-1:0] r_streak;
    logic                w_owner_d;
    logic [STREAK_W-1:0] w_streak_d;
    logic                w_any;
    logic                w_winner;

    always_comb begin
        w_any = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            w_winner = (r_streak < MaxStreak) ? r_owner : ~r_owner;
        end else if (i_req1) begin
            w_winner = PORT_HOST;
        end else begin
            w_winner = PORT_CPU;
        end
        // Grants are suppressed for the whole time reset is held low.
        o_gnt0 = i_rst_n & w_any & (w_winner == PORT_CPU);
        o_gnt1 = i_rst_n & w_any & (w_winner == PORT_HOST);
    end

    always_comb begin
        w_owner_d  = r_owner;
        w_streak_d = r_streak;
        if (!w_any) begin
            w_streak_d = '0;
        end else if (w_winner == r_owner) begin
            if (r_streak < MaxStreak) begin
                w_streak_d = r_streak + 1'b1;
            end
        end else begin
            w_owner_d  = w_winner;
            w_streak_d = STREAK_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner  <= PORT_CPU;
            r_streak <= '0;
        end else begin
            r_owner  <= w_owner_d;
            r_streak <= w_streak_d;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port DataRAM between the CPU (port 0) and the host loader (port 1),
// muxing the winner's command onto the RAM and returning registered read data.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RValid0,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic              Stall0,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDataIn,
    output logic              MemWR,
    input  logic [DATA_W-1:0] MemDataOut
);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_rd0;
    logic              w_rd1;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_last_wdata;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK)
    ) u_arb (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_req0  (Req0),
        .i_req1  (Req1),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    // With no winner the RAM address bus parks on the last command.
    always_comb begin
        MemAddr   = r_last_addr;
        MemDataIn = r_last_wdata;
        MemWR     = 1'b0;
        if (w_gnt0) begin
            MemAddr   = Addr0;
            MemDataIn = WData0;
            MemWR     = We0;
        end else if (w_gnt1) begin
            MemAddr   = Addr1;
            MemDataIn = WData1;
            MemWR     = We1;
        end
    end

    assign w_rd0 = w_gnt0 & ~We0;
    assign w_rd1 = w_gnt1 & ~We1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_last_addr  <= '0;
            r_last_wdata <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_last_addr  <= MemAddr;
            r_last_wdata <= MemDataIn;
            r_rvalid0    <= w_rd0;
            r_rvalid1    <= w_rd1;
            if (w_rd0) begin
                r_rdata0 <= MemDataOut;
            end
            if (w_rd1) begin
                r_rdata1 <= MemDataOut;
            end
        end
    end

    assign Gnt0    = w_gnt0;
    assign Gnt1    = w_gnt1;
    assign Stall0  = Req0 & ~w_gnt0;
    assign RValid0 = r_rvalid0;
    assign RValid1 = r_rvalid1;
    assign RData0  = r_rdata0;
    assign RData1  = r_rdata1;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a behavioural DataRAM behind the command bus.
module tb_dram_port_arbiter;

    logic        Clk;
    logic        Reset;
    logic        Req0, We0, Req1, We1;
    logic [4:0]  Addr0, Addr1;
    logic [31:0] WData0, WData1;
    logic        Gnt0, Gnt1, RValid0, RValid1, Stall0, MemWR;
    logic [31:0] RData0, RData1, MemDataIn, MemDataOut;
    logic [4:0]  MemAddr;

    logic [31:0] mem [32] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    dram_port_arbiter #(
        .ADDR_W     (5),
        .DATA_W     (32),
        .MAX_STREAK (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0       (Req0),
        .We0        (We0),
        .Addr0      (Addr0),
        .WData0     (WData0),
        .Req1       (Req1),
        .We1        (We1),
        .Addr1      (Addr1),
        .WData1     (WData1),
        .Gnt0       (Gnt0),
        .Gnt1       (Gnt1),
        .RValid0    (RValid0),
        .RValid1    (RValid1),
        .RData0     (RData0),
        .RData1     (RData1),
        .Stall0     (Stall0),
        .MemAddr    (MemAddr),
        .MemDataIn  (MemDataIn),
        .MemWR      (MemWR),
        .MemDataOut (MemDataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemWR) mem[MemAddr] <= MemDataIn;
    end
    assign MemDataOut = mem[MemAddr];

    task automatic test_reset();
        Reset = 1'b0; Req0 = 1'b1; We0 = 1'b0; Addr0 = 5'd0; WData0 = 32'h0;
        Req1 = 1'b0; We1 = 1'b0; Addr1 = 5'd0; WData1 = 32'h0;
        @(negedge Clk); #1;
        checks++; if (Gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got %b exp 0", Gnt0); end
        checks++; if (MemWR !== 1'b0) begin errors++; $display("FAIL reset_memwr got %b exp 0", MemWR); end
        checks++; if (RValid0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid0 got %b exp 0", RValid0); end
        checks++; if (RData0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", RData0); end
        checks++; if (Stall0 !== 1'b1) begin errors++; $display("FAIL reset_stall0 got %b exp 1", Stall0); end
        Reset = 1'b1; #1;
        checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL release_gnt0 got %b exp 1", Gnt0); end
        checks++; if (Stall0 !== 1'b0) begin errors++; $display("FAIL release_stall0 got %b exp 0", Stall0); end
        @(negedge Clk); Req0 = 1'b0; #1;
        checks++; if (RValid0 !== 1'b1) begin errors++; $display("FAIL release_rvalid0 got %b exp 1", RValid0); end
    endtask

    task automatic test_write_read();
        @(negedge Clk); Req0 = 1'b1; We0 = 1'b1; Addr0 = 5'd3; WData0 = 32'hDEADBEEF; #1;
        checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0 got %b exp 1", Gnt0); end
        checks++; if (MemWR !== 1'b1) begin errors++; $display("FAIL wr_memwr got %b exp 1", MemWR); end
        checks++; if (MemAddr !== 5'd3) begin errors++; $display("FAIL wr_memaddr got %0d exp 3", MemAddr); end
        checks++; if (MemDataIn !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_memdatain got %h exp deadbeef", MemDataIn); end
        checks++; if (Stall0 !== 1'b0) begin errors++; $display("FAIL wr_stall0 got %b exp 0", Stall0); end
        @(negedge Clk); We0 = 1'b0; #1;
        checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got %b exp 1", Gnt0); end
        checks++; if (MemWR !== 1'b0) begin errors++; $display("FAIL rd_memwr got %b exp 0", MemWR); end
        checks++; if (Stall0 !== 1'b0) begin errors++; $display("FAIL rd_stall0 got %b exp 0", Stall0); end
        checks++; if (RValid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", RValid0); end
        @(negedge Clk); Req0 = 1'b0; #1;
        checks++; if (RValid0 !== 1'b1) begin errors++; $display("FAIL rd_rvalid0 got %b exp 1", RValid0); end
        checks++; if (RData0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata0 got %h exp deadbeef", RData0); end
        checks++; if (Stall0 !== 1'b0) begin errors++; $display("FAIL rd_stall0_idle got %b exp 0", Stall0); end
        @(negedge Clk); #1;
        checks++; if (RValid0 !== 1'b0) begin errors++; $display("FAIL rvalid0_pulse got %b exp 0", RValid0); end
        checks++; if (RData0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata0_hold got %h exp deadbeef", RData0); end
        checks++; if (MemAddr !== 5'd3) begin errors++; $display("FAIL memaddr_hold got %0d exp 3", MemAddr); end
        checks++; if (Gnt0 !== 1'b0) begin errors++; $display("FAIL idle_gnt0 got %b exp 0", Gnt0); end
    endtask

    task automatic test_fairness();
        logic [8:0] pat;
        pat = 9'b0_1111_0000;  // bit i = expected winner in cycle i
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            Req0 = 1'b1; We0 = 1'b0; Addr0 = 5'd1;
            Req1 = 1'b1; We1 = 1'b0; Addr1 = 5'd2;
            #1;
            checks++; if (Gnt1 !== pat[i]) begin errors++; $display("FAIL fair_gnt1[%0d] got %b exp %b", i, Gnt1, pat[i]); end
            checks++; if (Gnt0 !== ~pat[i]) begin errors++; $display("FAIL fair_gnt0[%0d] got %b exp %b", i, Gnt0, ~pat[i]); end
            checks++; if (Stall0 !== pat[i]) begin errors++; $display("FAIL fair_stall0[%0d] got %b exp %b", i, Stall0, pat[i]); end
            checks++; if (MemAddr !== (pat[i] ? 5'd2 : 5'd1)) begin errors++; $display("FAIL fair_memaddr[%0d] got %0d", i, MemAddr); end
        end
        @(negedge Clk); Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic test_port1_read();
        @(negedge Clk); Req1 = 1'b1; We1 = 1'b1; Addr1 = 5'd31; WData1 = 32'h12345678; #1;
        checks++; if (Gnt1 !== 1'b1) begin errors++; $display("FAIL p1wr_gnt1 got %b exp 1", Gnt1); end
        checks++; if (MemWR !== 1'b1) begin errors++; $display("FAIL p1wr_memwr got %b exp 1", MemWR); end
        checks++; if (Gnt0 !== 1'b0) begin errors++; $display("FAIL p1wr_gnt0 got %b exp 0", Gnt0); end
        @(negedge Clk); We1 = 1'b0; #1;
        checks++; if (Gnt1 !== 1'b1) begin errors++; $display("FAIL p1rd_gnt1 got %b exp 1", Gnt1); end
        checks++; if (MemAddr !== 5'd31) begin errors++; $display("FAIL p1rd_memaddr got %0d exp 31", MemAddr); end
        checks++; if (RValid1 !== 1'b0) begin errors++; $display("FAIL p1wr_no_rvalid got %b exp 0", RValid1); end
        @(negedge Clk); Req1 = 1'b0; #1;
        checks++; if (RValid1 !== 1'b1) begin errors++; $display("FAIL p1rd_rvalid1 got %b exp 1", RValid1); end
        checks++; if (RData1 !== 32'h12345678) begin errors++; $display("FAIL p1rd_rdata1 got %h exp 12345678", RData1); end
        checks++; if (RValid0 !== 1'b0) begin errors++; $display("FAIL p1rd_rvalid0 got %b exp 0", RValid0); end
    endtask

    task automatic test_streak_reset();
        logic [4:0] pat;
        pat = 5'b10000;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk); Req0 = 1'b1; We0 = 1'b0; Addr0 = 5'd4; #1;
            checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL streak_pre_gnt0[%0d] got %b exp 1", i, Gnt0); end
        end
        @(negedge Clk); Req0 = 1'b0; #1;
        checks++; if ((Gnt0 | Gnt1) !== 1'b0) begin errors++; $display("FAIL streak_idle got %b%b exp 00", Gnt1, Gnt0); end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk); Req0 = 1'b1; Req1 = 1'b1; We1 = 1'b0; Addr1 = 5'd5; #1;
            checks++; if (Gnt1 !== pat[i]) begin errors++; $display("FAIL streak_gnt1[%0d] got %b exp %b", i, Gnt1, pat[i]); end
            checks++; if (Gnt0 !== ~pat[i]) begin errors++; $display("FAIL streak_gnt0[%0d] got %b exp %b", i, Gnt0, ~pat[i]); end
        end
        @(negedge Clk); Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        @(negedge Clk); Req1 = 1'b1; We1 = 1'b0; Addr1 = 5'd31; #1;
        checks++; if (Gnt1 !== 1'b1) begin errors++; $display("FAIL mid_gnt1 got %b exp 1", Gnt1); end
        #1 Reset = 1'b0; #1;
        checks++; if (Gnt1 !== 1'b0) begin errors++; $display("FAIL mid_gnt1_reset got %b exp 0", Gnt1); end
        checks++; if (RData1 !== 32'h0) begin errors++; $display("FAIL mid_rdata1_clear got %h exp 0", RData1); end
        Req1 = 1'b0; #1 Reset = 1'b1;
        @(negedge Clk); #1;
        checks++; if (RValid1 !== 1'b0) begin errors++; $display("FAIL mid_rvalid1 got %b exp 0", RValid1); end
        checks++; if (RData1 !== 32'h0) begin errors++; $display("FAIL mid_rdata1 got %h exp 0", RData1); end
        // Owner returns to port 0 after reset, so a contested cycle goes to port 0.
        @(negedge Clk); Req0 = 1'b1; Req1 = 1'b1; #1;
        checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL post_reset_owner got %b exp 1", Gnt0); end
        checks++; if (RValid1 !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid1 got %b exp 0", RValid1); end
        @(negedge Clk); Req0 = 1'b0; Req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fairness();
        test_port1_read();
        test_streak_reset();
        test_reset_mid_read();
        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
